// File: rtl/crop_pkg.sv
// crop_pkg: shared state, descriptor layout and box record for the crop stage.
package crop_pkg;
   typedef enum logic {WAIT_BOX, STREAM} state_t;
   localparam int ROW_BW = 10;
   localparam int COL_BW = 10;
   localparam int X1_LSB = 0;
   localparam int W_LSB = COL_BW;
   localparam int Y1_LSB = 2 * COL_BW;
   localparam int H_LSB = 2 * COL_BW + ROW_BW;
   localparam int DESC_W = 2 * ROW_BW + 2 * COL_BW;
   typedef struct packed {
      logic [COL_BW-1:0] x1;
      logic [COL_BW-1:0] w;
      logic [ROW_BW-1:0] y1;
      logic [ROW_BW-1:0] h;
   } box_t;
   function automatic box_t to_box(input logic [DESC_W-1:0] d);
      to_box.x1 = d[X1_LSB+:COL_BW];
      to_box.w = d[W_LSB+:COL_BW];
      to_box.y1 = d[Y1_LSB+:ROW_BW];
      to_box.h = d[H_LSB+:ROW_BW];
   endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: two-entry registered AXI-Stream slice; in_ready depends only on occupancy.
module axis_skid_buffer #(
   parameter int W = 8
)(
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);
   logic [W-1:0] skid;
   logic skid_vld, in_fire;
   assign in_ready = !skid_vld;
   assign in_fire = in_valid && in_ready;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         out_data <= '0;
         out_valid <= 1'b0;
         skid <= '0;
         skid_vld <= 1'b0;
      end else if (out_ready || !out_valid) begin
         out_valid <= skid_vld || in_fire;
         out_data <= skid_vld ? skid : (in_fire ? in_data : out_data);
         skid_vld <= 1'b0;
      end else if (in_fire) begin
         skid <= in_data;
         skid_vld <= 1'b1;
      end
endmodule

// File: rtl/crop_window_stream.sv
// crop_window_stream: forwards only the pixels of each raster frame that fall inside
// a per-frame crop box, with one-deep descriptor prefetch and a registered skid output.
module crop_window_stream
   import crop_pkg::*;
#(
   parameter int PIXEL_BIT_WIDTH = 12,
   parameter int IN_ROWS = 40,
   parameter int IN_COLS = 40,
   parameter int IMG_ROW_BITWIDTH = ROW_BW,
   parameter int IMG_COL_BITWIDTH = COL_BW
)(
   input  logic clk,
   input  logic reset,
   input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA,
   input  logic pixel_in_TUSER,
   input  logic pixel_in_TVALID,
   output logic pixel_in_TREADY,
   input  logic [2*IMG_ROW_BITWIDTH+2*IMG_COL_BITWIDTH-1:0] crop_TDATA,
   input  logic crop_TVALID,
   output logic crop_TREADY,
   output logic [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA,
   output logic pixel_out_TUSER,
   output logic pixel_out_TLAST,
   output logic pixel_out_TVALID,
   input  logic pixel_out_TREADY,
   output logic frame_err
);
   localparam int CB = IMG_COL_BITWIDTH;
   localparam int RB = IMG_ROW_BITWIDTH;
   localparam logic [CB-1:0] X_LAST = CB'(IN_COLS - 1);
   localparam logic [RB-1:0] Y_LAST = RB'(IN_ROWS - 1);
   localparam logic [CB:0] COLS = (CB+1)'(IN_COLS);
   localparam logic [RB:0] ROWS = (RB+1)'(IN_ROWS);
   state_t state, state_d;
   box_t act, pend;
   logic pend_vld, live, skid_rdy, in_fire, crop_fire, resync, last, pass, tuser, tlast;
   logic [CB-1:0] x, ex;
   logic [RB-1:0] y, ey;
   logic [CB:0] xs, xe;
   logic [RB:0] ys, ye;
   assign pixel_in_TREADY = state == STREAM && skid_rdy;
   assign crop_TREADY = live && (state == WAIT_BOX || !pend_vld);
   assign in_fire = pixel_in_TVALID && pixel_in_TREADY;
   assign crop_fire = crop_TVALID && crop_TREADY;
   // A stray start-of-frame restarts the raster at (0,0) without touching the boxes.
   assign resync = in_fire && pixel_in_TUSER && (x != '0 || y != '0);
   assign ex = resync ? '0 : x;
   assign ey = resync ? '0 : y;
   assign last = in_fire && ex == X_LAST && ey == Y_LAST;
   assign xs = {1'b0, act.x1} + {1'b0, act.w};
   assign ys = {1'b0, act.y1} + {1'b0, act.h};
   assign xe = xs > COLS ? COLS : xs;
   assign ye = ys > ROWS ? ROWS : ys;
   assign pass = ex >= act.x1 && {1'b0, ex} < xe && ey >= act.y1 && {1'b0, ey} < ye;
   assign tuser = ex == act.x1 && ey == act.y1;
   assign tlast = {1'b0, ex} == xe - (CB+1)'(1);
   always_comb begin
      state_d = state;
      if (state == WAIT_BOX && crop_fire) state_d = STREAM;
      else if (state == STREAM && last && !pend_vld && !crop_fire) state_d = WAIT_BOX;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= WAIT_BOX;
         live <= 1'b0;
         x <= '0;
         y <= '0;
         act <= '0;
         pend <= '0;
         pend_vld <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state <= state_d;
         live <= 1'b1;
         if (resync) frame_err <= 1'b1;
         if (in_fire) begin
            x <= ex == X_LAST ? '0 : ex + CB'(1);
            y <= ex == X_LAST ? (ey == Y_LAST ? '0 : ey + RB'(1)) : ey;
         end
         if (state == WAIT_BOX) begin
            if (crop_fire) act <= to_box(crop_TDATA);
         end else if (last && pend_vld) begin
            act <= pend;
            pend_vld <= 1'b0;
         end else if (last && crop_fire) act <= to_box(crop_TDATA);
         else if (crop_fire) begin
            pend <= to_box(crop_TDATA);
            pend_vld <= 1'b1;
         end
      end
   axis_skid_buffer #(.W(PIXEL_BIT_WIDTH + 2)) u_skid (
      .clk(clk),
      .reset(reset),
      .in_data({tuser, tlast, pixel_in_TDATA}),
      .in_valid(in_fire && pass),
      .in_ready(skid_rdy),
      .out_data({pixel_out_TUSER, pixel_out_TLAST, pixel_out_TDATA}),
      .out_valid(pixel_out_TVALID),
      .out_ready(pixel_out_TREADY)
   );
endmodule

// File: doc/crop_window_stream.md
# crop_window_stream

Parametrised streaming crop stage: takes a raster-order pixel stream of fixed IN_ROWS×IN_COLS frames and forwards only pixels inside a per-frame, runtime-programmable crop box of variable origin and size. Box descriptors arrive on their own AXI-Stream channel, one per frame. A one-deep descriptor prefetch lets back-to-back frames stream without bubbles. Output is registered through a skid buffer and carries start-of-frame (TUSER) and end-of-row (TLAST) markers for downstream filters such as the Gaussian stage.

## Interface
- PIXEL_BIT_WIDTH, 12, pixel width
- IN_ROWS, 40, input frame height
- IN_COLS, 40, input frame width
- IMG_ROW_BITWIDTH, 10, row coordinate/size width; must hold IN_ROWS
- IMG_COL_BITWIDTH, 10, column coordinate/size width; must hold IN_COLS
- clk  in  1  sole clock; everything is on posedge
- reset  in  1  asynchronous, active-low (0 = in reset)
- pixel_in_TDATA  in  PIXEL_BIT_WIDTH  input pixel
- pixel_in_TUSER  in  1  start-of-frame; high on pixel (0,0)
- pixel_in_TVALID / pixel_in_TREADY  in / out  1  input handshake
- crop_TDATA  in  2*IMG_ROW_BITWIDTH+2*IMG_COL_BITWIDTH  packed {H, Y1, W, X1}, with X1 in the LSBs
- crop_TVALID / crop_TREADY  in / out  1  descriptor handshake
- pixel_out_TDATA  out  PIXEL_BIT_WIDTH  cropped pixel
- pixel_out_TUSER  out  1  first pixel of a cropped frame
- pixel_out_TLAST  out  1  last pixel of each cropped row
- pixel_out_TVALID / pixel_out_TREADY  out / in  1  output handshake
- frame_err  out  1  sticky; set on a SOF/counter mismatch; cleared only by reset

## Operation
- States are WAIT_BOX and STREAM.
- **WAIT_BOX**
  - pixel_in_TREADY=0, crop_TREADY=1.
  - A descriptor handshake latches the active box and moves to STREAM.
- **STREAM**
  - pixel_in_TREADY = skid buffer not full.
  - crop_TREADY = pending slot empty. A descriptor accepted here goes to the pending slot.
- **Counters**
  - x/y advance on each input handshake in raster order and wrap to (0,0) after (IN_COLS-1, IN_ROWS-1).
- **Frame end** (handshake at the last pixel):
  - If pending is valid, load it into active, clear pending, stay in STREAM.
  - Otherwise go to WAIT_BOX.
  - If a descriptor handshakes in the same cycle as frame end, it loads directly into active.
- **Pass test**
  - X1 ≤ x < Xe and Y1 ≤ y < Ye.
  - Xe = min(X1+W, IN_COLS) and Ye = min(Y1+H, IN_ROWS), with sums in width+1 bits so there is no wrap.
  - W=0, H=0, X1≥IN_COLS or Y1≥IN_ROWS gives an empty box: the frame is consumed and nothing is emitted.
- **Markers**
  - TUSER = passing pixel with x==X1 and y==Y1.
  - TLAST = passing pixel with x==Xe-1.
- **Resync**
  - If pixel_in_TUSER=1 on a handshake while (x,y)≠(0,0), that pixel is treated as (0,0) and frame_err is set.
  - The active box is kept. Pending is not consumed.
- Failing pixels are accepted and dropped without back-pressure.

## Timing
- **Reset values**
  - pixel_in_TREADY=0, crop_TREADY=0, pixel_out_TVALID=0, TUSER=0, TLAST=0, TDATA=0, frame_err=0.
  - State is WAIT_BOX; counters are 0; pending is invalid.
  - crop_TREADY rises on the first clock after reset deasserts.
- **Latency:** a passing input handshake at cycle n gives pixel_out_TVALID at cycle n+1.
- **Throughput:** one pixel per cycle sustained when pixel_out_TREADY=1.
- **Skid buffer**
  - Two entries. pixel_in_TREADY is registered and is a function of buffer occupancy only, not combinational from pixel_out_TREADY.
  - Output data and markers stay stable while TVALID=1 and TREADY=0.
- **Reset mid-frame:** all state is cleared immediately, buffered output is discarded, and the block waits for a new descriptor.
- **Descriptor timing:** the active box changes only at frame end. A mid-frame descriptor never affects the current frame.

## Structure
- **Package crop_pkg**
  - State enum {WAIT_BOX, STREAM}.
  - Descriptor field offsets/widths as localparams derived from IMG_ROW_BITWIDTH and IMG_COL_BITWIDTH.
  - A box record typedef {x1, w, y1, h}.
- **Sub-module axis_skid_buffer:** parametrised on data width, carrying {TUSER, TLAST, TDATA}; reusable by the filter stages.
- **Top level:** counters, FSM, descriptor slots and pass logic.

## Test plan
All scenarios use IN 8×8 and pixel value = 8y+x.
- **Basic crop:** box X1=3, Y1=2, W=3, H=2 with out_TREADY=1 → outputs 19,20,21,27,28,29. TUSER on 19, TLAST on 21 and 29. Each output arrives 1 cycle after its input.
- **Edge clipping:** box X1=6, Y1=7, W=5, H=4 → outputs 62,63. TLAST on 63. TUSER on 62.
- **Prefetch:** descriptor B sent mid-frame A, then two frames streamed back-to-back → no input stall at the boundary. Frame 2 uses box B. crop_TREADY=0 until B moves to active.
- **Back-pressure:** out_TREADY toggled 1010… during the basic crop → same 6 values in order, none lost or duplicated. in_TREADY drops only when the skid buffer is full.
- **Resync:** TUSER asserted at the 20th input pixel → frame_err=1. That pixel is treated as (0,0), so the next output is the 20th-after pixel matching (3,2).
- **Empty box and reset:** W=0 frame → 64 inputs accepted, no output, returns to WAIT_BOX. Asserting reset during a frame → all outputs go to 0 within the same cycle.
